chip8_sprite_engine: RTL and testbench



---
 rtl/chip8_sprite_engine.sv | 131 +++++++++++++
 tb/tb_chip8_sprite_engine.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/chip8_sprite_engine.sv
// chip8_sprite_engine: executes one CHIP-8 DRW by XOR-blitting an n-row sprite into the shared-memory framebuffer
module chip8_sprite_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        draw,
  input  logic [11:0] addr,
  input  logic [3:0]  lines,
  input  logic [5:0]  x,
  input  logic [4:0]  y,
  output logic        busy,
  output logic        collision,
  output logic        mem_read,
  output logic [11:0] mem_read_idx,
  input  logic [7:0]  mem_read_byte,
  input  logic        mem_read_ack,
  output logic        mem_write,
  output logic [11:0] mem_write_idx,
  output logic [7:0]  mem_write_byte
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD_SPR = 3'd1;
  localparam logic [2:0] RD_L = 3'd2;
  localparam logic [2:0] WR_L = 3'd3;
  localparam logic [2:0] RD_R = 3'd4;
  localparam logic [2:0] WR_R = 3'd5;
  localparam logic [2:0] FINISH = 3'd6;
  logic [2:0]  state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [3:0]  lines_q, lines_d, i_q, i_d;
  logic [5:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [7:0]  spr_q, spr_d, old_q, old_d;
  logic        coll_q, coll_d;
  logic [4:0]  row;
  logic [2:0]  col;
  logic [2:0]  sh;
  logic [7:0]  left_bits, right_bits, patt;
  logic [11:0] fb_idx;
  logic [2:0]  next_row;
  logic        right_half;
  // Datapath: framebuffer address of the byte under the sprite and the shifted sprite halves
  always_comb begin
    row = y_q + {1'b0, i_q};
    sh = x_q[2:0];
    right_half = (state_q == RD_R) || (state_q == WR_R);
    col = right_half ? x_q[5:3] + 3'd1 : x_q[5:3];
    fb_idx = {4'h1, row, col};
    left_bits = spr_q >> sh;
    right_bits = spr_q << (4'd8 - {1'b0, sh});
    patt = right_half ? right_bits : left_bits;
    next_row = (i_q + 4'd1 == lines_q) ? FINISH : RD_SPR;
    busy = state_q != IDLE;
    collision = coll_q;
    mem_read = ((state_q == RD_SPR) || (state_q == RD_L) || (state_q == RD_R)) && !mem_read_ack;
    mem_read_idx = (state_q == RD_SPR) ? addr_q + {8'h00, i_q} : fb_idx;
    mem_write = (state_q == WR_L) || (state_q == WR_R);
    mem_write_idx = fb_idx;
    mem_write_byte = old_q ^ patt;
  end
  // Next-state logic: one read per sprite byte, then read-modify-write of one or two framebuffer bytes
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    lines_d = lines_q;
    x_d = x_q;
    y_d = y_q;
    i_d = i_q;
    spr_d = spr_q;
    old_d = old_q;
    coll_d = coll_q;
    case (state_q)
      IDLE: if (draw) begin
        addr_d = addr;
        lines_d = lines;
        x_d = x;
        y_d = y;
        i_d = 4'd0;
        coll_d = 1'b0;
        state_d = (lines == 4'd0) ? FINISH : RD_SPR;
      end
      RD_SPR: if (mem_read_ack) begin
        spr_d = mem_read_byte;
        state_d = RD_L;
      end
      RD_L: if (mem_read_ack) begin
        old_d = mem_read_byte;
        state_d = WR_L;
      end
      WR_L: begin
        coll_d = coll_q | (|(old_q & left_bits));
        state_d = (sh != 3'd0) ? RD_R : next_row;
        i_d = (sh != 3'd0) ? i_q : i_q + 4'd1;
      end
      RD_R: if (mem_read_ack) begin
        old_d = mem_read_byte;
        state_d = WR_R;
      end
      WR_R: begin
        coll_d = coll_q | (|(old_q & right_bits));
        state_d = next_row;
        i_d = i_q + 4'd1;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State registers; reset abandons any draw in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= 12'h000;
      lines_q <= 4'd0;
      x_q <= 6'd0;
      y_q <= 5'd0;
      i_q <= 4'd0;
      spr_q <= 8'h00;
      old_q <= 8'h00;
      coll_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      lines_q <= lines_d;
      x_q <= x_d;
      y_q <= y_d;
      i_q <= i_d;
      spr_q <= spr_d;
      old_q <= old_d;
      coll_q <= coll_d;
    end
  end
endmodule

// File: tb/tb_chip8_sprite_engine.sv
// tb_chip8_sprite_engine: directed and randomized DRW checks against a pixel-level reference model
module tb_chip8_sprite_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        draw = 1'b0;
  logic [11:0] addr = 12'h000;
  logic [3:0]  lines = 4'd0;
  logic [5:0]  x = 6'd0;
  logic [4:0]  y = 5'd0;
  logic        busy, collision, mem_read, mem_write;
  logic [11:0] mem_read_idx, mem_write_idx;
  logic [7:0]  mem_write_byte;
  logic [7:0]  rd_byte = 8'h00;
  logic        rd_ack;
  logic [7:0]  mem [4096];
  logic [7:0]  refm [4096];
  logic        host_we = 1'b0, host_clr = 1'b0;
  logic [11:0] host_idx = 12'h000;
  logic [7:0]  host_dat = 8'h00;
  int          acc_cnt = 0;
  int          checks = 0, failures = 0;
  int          cycles;

  chip8_sprite_engine dut (
    .clk(clk), .rst_n(rst_n), .draw(draw), .addr(addr), .lines(lines), .x(x), .y(y),
    .busy(busy), .collision(collision), .mem_read(mem_read), .mem_read_idx(mem_read_idx),
    .mem_read_byte(rd_byte), .mem_read_ack(rd_ack), .mem_write(mem_write),
    .mem_write_idx(mem_write_idx), .mem_write_byte(mem_write_byte)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_ack <= 1'b0;
    else begin
      rd_ack <= mem_read;
      if (mem_read) rd_byte <= mem[mem_read_idx];
      if (mem_write) mem[mem_write_idx] <= mem_write_byte;
      if (mem_read || mem_write) acc_cnt <= acc_cnt + 1;
      if (host_we) mem[host_idx] <= host_dat;
      if (host_clr) for (int k = 0; k < 4096; k++) mem[k] <= 8'h00;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_idx = a; host_dat = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic clear_mem();
    @(negedge clk);
    host_clr = 1'b1;
    @(negedge clk);
    host_clr = 1'b0;
  endtask

  task automatic do_draw(input logic [11:0] a, input logic [3:0] l, input logic [5:0] xx,
                         input logic [4:0] yy, input bit mid);
    @(negedge clk);
    addr = a; lines = l; x = xx; y = yy; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 300) begin
      cycles++;
      if (mid && cycles == 3) begin
        draw = 1'b1; addr = 12'h301; x = 6'd13; y = 5'd7; lines = 4'd4;
      end else draw = 1'b0;
      @(negedge clk);
    end
    draw = 1'b0;
  endtask

  task automatic model_draw(input logic [11:0] a, input int l, input int xx, input int yy,
                            output logic mc);
    logic [7:0] sb;
    int px, py, idx, bt;
    mc = 1'b0;
    for (int j = 0; j < l; j++) begin
      sb = refm[(int'(a) + j) % 4096];
      for (int b = 0; b < 8; b++) begin
        if (sb[7-b]) begin
          px = (xx + b) % 64;
          py = (yy + j) % 32;
          idx = 256 + py * 8 + px / 8;
          bt = 7 - px % 8;
          if (refm[idx][bt]) mc = 1'b1;
          refm[idx][bt] = ~refm[idx][bt];
        end
      end
    end
  endtask

  initial begin : main
    logic [11:0] ra;
    logic [3:0]  rl;
    logic [5:0]  rx;
    logic [4:0]  ry;
    logic        mc;
    int          bad, acc0, exp_cyc;
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_collision", collision, 0);
    chk("reset_mem_read", mem_read, 0);
    chk("reset_mem_write", mem_write, 0);
    clear_mem();
    poke(12'h300, 8'hF0);
    poke(12'h301, 8'hFF);
    poke(12'h302, 8'h80);
    poke(12'h303, 8'h80);
    do_draw(12'h300, 4'd1, 6'd0, 5'd0, 0);
    chk("f0_byte", mem[12'h100], 8'hF0);
    chk("f0_coll", collision, 0);
    chk("f0_busy_cycles", cycles, 6);
    do_draw(12'h300, 4'd1, 6'd0, 5'd0, 0);
    chk("f0_again_byte", mem[12'h100], 8'h00);
    chk("f0_again_coll", collision, 1);
    do_draw(12'h301, 4'd1, 6'd4, 5'd1, 0);
    chk("x4_left", mem[12'h108], 8'h0F);
    chk("x4_right", mem[12'h109], 8'hF0);
    chk("x4_coll", collision, 0);
    chk("x4_busy_cycles", cycles, 9);
    do_draw(12'h301, 4'd1, 6'd60, 5'd0, 0);
    chk("hwrap_left", mem[12'h107], 8'h0F);
    chk("hwrap_right", mem[12'h100], 8'hF0);
    chk("hwrap_coll", collision, 0);
    clear_mem();
    poke(12'h300, 8'hF0);
    poke(12'h301, 8'hFF);
    poke(12'h302, 8'h80);
    poke(12'h303, 8'h80);
    do_draw(12'h302, 4'd2, 6'd0, 5'd31, 1);
    chk("vwrap_row31", mem[12'h1F8], 8'h80);
    chk("vwrap_row0", mem[12'h100], 8'h80);
    chk("vwrap_busy_cycles_ignore_draw", cycles, 11);
    chk("vwrap_row7_untouched", mem[12'h139], 8'h00);
    chk("vwrap_idle_after", busy, 0);
    for (int t = 0; t < 40; t++) begin
      ra = 12'($urandom_range(12'h200, 12'hFFF));
      rl = 4'($urandom_range(0, 15));
      rx = 6'($urandom);
      ry = 5'($urandom);
      for (int j = 0; j < int'(rl); j++) poke(ra + 12'(j), 8'($urandom));
      for (int k = 0; k < 4096; k++) refm[k] = mem[k];
      model_draw(ra, int'(rl), int'(rx), int'(ry), mc);
      do_draw(ra, rl, rx, ry, 0);
      exp_cyc = (rl == 4'd0) ? 1 : int'(rl) * ((rx[2:0] != 3'd0) ? 8 : 5) + 1;
      chk("rand_busy_cycles", cycles, exp_cyc);
      chk("rand_coll", collision, mc);
      bad = -1;
      for (int k = 256; k < 512; k++) if (mem[k] !== refm[k] && bad < 0) bad = k;
      chk("rand_fb_first_bad_idx", bad, 32'hFFFFFFFF);
    end
    @(negedge clk);
    addr = 12'h301; lines = 4'd3; x = 6'd3; y = 5'd5; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_mem_read", mem_read, 0);
    chk("rst_mid_mem_write", mem_write, 0);
    chk("rst_mid_collision", collision, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    acc0 = acc_cnt;
    do_draw(12'h300, 4'd0, 6'd9, 5'd9, 0);
    chk("zero_lines_busy_cycles", cycles, 1);
    chk("zero_lines_no_access", acc_cnt - acc0, 0);
    chk("zero_lines_coll", collision, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
